// File: rtl/shared_compute_arbiter.sv
// Time-shares one compute unit among NUM_UNITS requesters: round-robin or fixed-priority
// arbitration, start/done handshake, watchdog abort and a saturating busy-cycle counter.
module shared_compute_arbiter #(
    parameter int NUM_UNITS   = 4,
    parameter int ID_W        = $clog2(NUM_UNITS),
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_rr,
    input  logic [NUM_UNITS-1:0] req,
    output logic [NUM_UNITS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    input  logic                 cu_ready,
    output logic                 cu_start,
    input  logic                 cu_done,
    output logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_abort,
    output logic                 timeout_err,
    input  logic                 clr,
    output logic [CNT_W-1:0]     busy_cnt
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [TO_W-1:0]        tcnt_q;
    logic [NUM_UNITS-1:0]   grant_q;
    logic [ID_W-1:0]        grant_id_q;
    logic                   cu_start_q;
    logic [NUM_UNITS-1:0]   unit_done_q;
    logic [NUM_UNITS-1:0]   unit_abort_q;
    logic                   timeout_err_q;
    logic [CNT_W-1:0]       busy_cnt_q;

    logic [ID_W-1:0]        win_id_d;
    logic                   win_found_d;
    logic [ID_W-1:0]        cand;
    int unsigned            base;
    logic [NUM_UNITS-1:0]   id_onehot;

    // Fixed priority is the rotating search with its start forced to index 0.
    always_comb begin
        win_id_d    = '0;
        win_found_d = 1'b0;
        cand        = '0;
        base        = mode_rr ? 32'(rr_ptr_q) : 32'd0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            cand = ID_W'((base + i) % NUM_UNITS);
            if (!win_found_d && req[cand]) begin
                win_found_d = 1'b1;
                win_id_d    = cand;
            end
        end
    end

    assign id_onehot = NUM_UNITS'(1) << grant_id_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            tcnt_q        <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            cu_start_q    <= 1'b0;
            unit_done_q   <= '0;
            unit_abort_q  <= '0;
            timeout_err_q <= 1'b0;
            busy_cnt_q    <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                if (busy_cnt_q != '1)
                    busy_cnt_q <= busy_cnt_q + CNT_W'(1);
            end else if (clr) begin
                busy_cnt_q <= '0;
            end
            if (clr)
                timeout_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (win_found_d && cu_ready) begin
                        grant_id_q <= win_id_d;
                        grant_q    <= NUM_UNITS'(1) << win_id_d;
                        cu_start_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cu_start_q <= 1'b0;
                    tcnt_q     <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes precedence over a watchdog expiry in the same cycle.
                    if (cu_done) begin
                        unit_done_q <= id_onehot;
                        grant_q     <= '0;
                        state_q     <= S_RELEASE;
                    end else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        unit_abort_q  <= id_onehot;
                        timeout_err_q <= 1'b1;
                        grant_q       <= '0;
                        state_q       <= S_RELEASE;
                    end else begin
                        tcnt_q <= tcnt_q + TO_W'(1);
                    end
                end
                S_RELEASE: begin
                    unit_done_q  <= '0;
                    unit_abort_q <= '0;
                    rr_ptr_q     <= (grant_id_q == ID_W'(NUM_UNITS - 1)) ? '0
                                    : grant_id_q + ID_W'(1);
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign cu_start    = cu_start_q;
    assign unit_done   = unit_done_q;
    assign unit_abort  = unit_abort_q;
    assign timeout_err = timeout_err_q;
    assign busy_cnt    = busy_cnt_q;

endmodule
